// File: rtl/mario_sprite_fetch.sv
// mario_sprite_fetch: 2-stage sprite ROM fetch and compositing over background (MARIO_MIRROR_EN enables horizontal mirroring)
module mario_sprite_fetch #(
  parameter int SPR_W = 21,
  parameter int SPR_H = 41,
  parameter logic [23:0] KEY_COLOR = 24'h800080
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        pixel_valid_in,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  mario_x,
  input  logic [9:0]  mario_y,
  input  logic        facing_left,
  input  logic        blink,
  input  logic [23:0] bg_color,
  output logic [9:0]  read_address,
  input  logic [23:0] rom_color,
  output logic [23:0] pixel_color,
  output logic        pixel_valid_out,
  output logic        sprite_hit
);
  logic [9:0] px, py, col, row, col_m, addr_n;
  logic [2:0] frame_cnt;
  logic pface, inbox, inbox_d1, pixel_valid_d1, opaque;
  logic [23:0] bg_color_d1;
`ifdef MARIO_MIRROR_EN
  always_ff @(posedge Clk) pface <= Reset ? 1'b0 : frame_start ? facing_left : pface;
`else
  logic unused_facing;
  assign pface = 1'b0;
  assign unused_facing = facing_left;
`endif
  always_comb begin
    inbox = {1'b0, DrawX} >= {1'b0, px} && {1'b0, DrawX} < {1'b0, px} + 11'(SPR_W) &&
            {1'b0, DrawY} >= {1'b0, py} && {1'b0, DrawY} < {1'b0, py} + 11'(SPR_H);
    col = DrawX - px;
    row = DrawY - py;
    col_m = pface ? 10'(SPR_W - 1) - col : col;
    addr_n = inbox ? row * 10'(SPR_W) + col_m : '0;
    opaque = inbox_d1 && pixel_valid_d1 && rom_color != KEY_COLOR && !(blink && frame_cnt[2]);
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      px <= '0;
      py <= '0;
      frame_cnt <= '0;
      read_address <= '0;
      inbox_d1 <= 1'b0;
      pixel_valid_d1 <= 1'b0;
      bg_color_d1 <= '0;
      pixel_color <= '0;
      sprite_hit <= 1'b0;
      pixel_valid_out <= 1'b0;
    end else begin
      if (frame_start) begin
        px <= mario_x;
        py <= mario_y;
        frame_cnt <= frame_cnt + 3'd1;
      end
      read_address <= addr_n;
      inbox_d1 <= inbox;
      pixel_valid_d1 <= pixel_valid_in;
      bg_color_d1 <= bg_color;
      pixel_color <= opaque ? rom_color : bg_color_d1;
      sprite_hit <= opaque;
      pixel_valid_out <= pixel_valid_d1;
    end
  end
endmodule

// File: tb/tb_mario_sprite_fetch.sv
// tb_mario_sprite_fetch: directed vectors against a coordinate-arithmetic model of the sprite fetch
module tb_mario_sprite_fetch;
  localparam int W = 21, H = 41;
  localparam logic [23:0] KEY = 24'h800080, SKY = 24'h5C94FC, RED = 24'hF83800;
  logic Clk = 0, Reset = 1, frame_start = 0, pixel_valid_in = 0, facing_left = 0, blink = 0;
  logic [9:0] DrawX = 0, DrawY = 0, mario_x = 0, mario_y = 0, read_address;
  logic [23:0] bg_color = 0, rom_color, pixel_color;
  logic pixel_valid_out, sprite_hit;
  int vectors = 0, errs = 0;
  int m_px, m_py, m_cnt, e_ra;
  bit m_face, started = 0, e_in1, e_v1, e_v, e_hit;
  logic [23:0] e_bg1, e_col;

  mario_sprite_fetch dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pixel_valid_in(pixel_valid_in),
    .DrawX(DrawX), .DrawY(DrawY), .mario_x(mario_x), .mario_y(mario_y),
    .facing_left(facing_left), .blink(blink), .bg_color(bg_color),
    .read_address(read_address), .rom_color(rom_color), .pixel_color(pixel_color),
    .pixel_valid_out(pixel_valid_out), .sprite_hit(sprite_hit)
  );

  always #5 Clk = ~Clk;

  function automatic logic [23:0] rom_f(input int a);
    return a == 860 ? RED : (a % 5 == 2) ? KEY : 24'h100000 + 24'(a);
  endfunction

  assign rom_color = rom_f(int'(read_address));

  task automatic chk(input string n, input logic [23:0] a, input logic [23:0] e);
    vectors++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  always @(posedge Clk) begin : model
    int c, r;
    bit inb, op;
    logic [23:0] rc;
    started <= 1'b1;
    if (Reset) begin
      m_px <= 0; m_py <= 0; m_cnt <= 0; m_face <= 0;
      e_ra <= 0; e_in1 <= 0; e_v1 <= 0; e_bg1 <= 0; e_col <= 0; e_hit <= 0; e_v <= 0;
    end else begin
      c = int'(DrawX) - m_px;
      r = int'(DrawY) - m_py;
      inb = c >= 0 && c < W && r >= 0 && r < H;
      if (m_face) c = W - 1 - c;
      rc = rom_f(e_ra);
      op = e_in1 && e_v1 && rc != KEY && !(blink && m_cnt >= 4);
      e_ra <= inb ? r * W + c : 0;
      e_in1 <= inb;
      e_v1 <= pixel_valid_in;
      e_bg1 <= bg_color;
      e_col <= op ? rc : e_bg1;
      e_hit <= op;
      e_v <= e_v1;
      if (frame_start) begin
        m_px <= int'(mario_x);
        m_py <= int'(mario_y);
        m_cnt <= (m_cnt + 1) % 8;
`ifdef MARIO_MIRROR_EN
        m_face <= facing_left;
`endif
      end
    end
  end

  always @(negedge Clk) if (started) begin
    chk("model_addr", 24'(read_address), 24'(e_ra));
    chk("model_valid", 24'(pixel_valid_out), 24'(e_v));
    chk("model_hit", 24'(sprite_hit), 24'(e_hit));
    chk("model_color", pixel_color, e_col);
  end

  task automatic pulse();
    @(negedge Clk); frame_start = 1;
    @(negedge Clk); frame_start = 0;
  endtask

  task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic [23:0] bg,
                       input logic [9:0] ra, input logic [23:0] col, input logic hit, input logic fs);
    @(negedge Clk);
    DrawX = x; DrawY = y; bg_color = bg; pixel_valid_in = 1; frame_start = fs;
    @(negedge Clk);
    pixel_valid_in = 0; frame_start = 0;
    chk("addr", 24'(read_address), 24'(ra));
    @(negedge Clk);
    chk("color", pixel_color, col);
    chk("hit", 24'(sprite_hit), 24'(hit));
    chk("valid", 24'(pixel_valid_out), 24'd1);
  endtask

  initial begin
    frame_start = 1; mario_x = 50; mario_y = 60;
    repeat (2) @(negedge Clk);
    chk("rst_addr", 24'(read_address), 24'd0);
    chk("rst_color", pixel_color, 24'd0);
    chk("rst_valid", 24'(pixel_valid_out), 24'd0);
    chk("rst_hit", 24'(sprite_hit), 24'd0);
    Reset = 0; frame_start = 0;
    probe(0, 0, SKY, 0, 24'h100000, 1, 0);
    mario_x = 100; mario_y = 200;
    pulse();
    probe(100, 200, SKY, 0, 24'h100000, 1, 0);
    probe(120, 240, SKY, 860, RED, 1, 0);
    probe(121, 200, SKY, 0, SKY, 0, 0);
    probe(100, 241, 24'h00A800, 0, 24'h00A800, 0, 0);
    probe(102, 200, 24'h123456, 2, 24'h123456, 0, 0);
    facing_left = 1;
    pulse();
`ifdef MARIO_MIRROR_EN
    probe(120, 240, SKY, 840, 24'h100348, 1, 0);
    probe(100, 200, SKY, 20, 24'h100014, 1, 0);
`else
    probe(120, 240, SKY, 860, RED, 1, 0);
    probe(100, 200, SKY, 0, 24'h100000, 1, 0);
`endif
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      DrawX = 10'(95 + i); DrawY = 10'(198 + 2 * i); bg_color = 24'(i * 3); pixel_valid_in = i[0];
    end
    facing_left = 0;
    pulse();
    blink = 1;
    probe(120, 240, SKY, 860, RED, 1, 0);
    pulse();
    probe(120, 240, SKY, 860, SKY, 0, 0);
    pulse();
    pulse();
    pulse();
    probe(120, 240, SKY, 860, SKY, 0, 0);
    pulse();
    probe(120, 240, SKY, 860, RED, 1, 0);
    blink = 0;
    mario_x = 1020; mario_y = 200;
    probe(101, 200, SKY, 1, 24'h100001, 1, 1);
    probe(1023, 200, SKY, 3, 24'h100003, 1, 0);
    probe(5, 200, SKY, 0, SKY, 0, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      DrawX = 10'(1016 + i); DrawY = 10'(199 + i); bg_color = 24'(i); pixel_valid_in = (i % 3 != 0);
    end
    @(negedge Clk);
    DrawX = 1021; DrawY = 201; pixel_valid_in = 1;
    @(negedge Clk);
    Reset = 1; pixel_valid_in = 0;
    @(negedge Clk);
    Reset = 0;
    chk("flush_valid", 24'(pixel_valid_out), 24'd0);
    probe(0, 0, SKY, 0, 24'h100000, 1, 0);
    repeat (3) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
